// File: rtl/fpaddsub_norm_sequencer.sv
// Multi-cycle normalizer for the FP add/sub mantissa sum: left-shifts in 16/8/4/2/1 steps
// until the MSB is set, tracking exponent and total shift, with valid/ready on both sides.
module fpaddsub_norm_sequencer #(
   parameter int MW = 26,
   parameter int EW = 8,
   parameter int SW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [MW-1:0] in_sum,
   input  logic [EW-1:0] in_exp,
   input  logic          in_sign,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [MW-1:0] out_mant,
   output logic [EW-1:0] out_exp,
   output logic          out_sign,
   output logic [SW-1:0] out_shift,
   output logic          out_zero,
   output logic          out_uflow,
   output logic [1:0]    dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready is high only in IDLE; out_valid, once raised, holds with stable data until
   // out_ready is seen, and no input is taken on the edge of the output transfer.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [MW-1:0] mant_q, mant_d;
   logic [EW-1:0] exp_q, exp_d;
   logic [SW-1:0] shift_q, shift_d;
   logic          sign_q, sign_d;
   logic          zero_q, zero_d;
   logic          uflow_q, uflow_d;
   logic          valid_q, valid_d;

   logic [4:0]    step;
   logic [SW:0]   shift_sum;

   // Largest step that keeps the top bits zero and leaves the exponent at 1 or more.
   always_comb begin
      step = 5'd0;
      if (mant_q[MW-1 -: 16] == '0 && exp_q > EW'(16))
         step = 5'd16;
      else if (mant_q[MW-1 -: 8] == '0 && exp_q > EW'(8))
         step = 5'd8;
      else if (mant_q[MW-1 -: 4] == '0 && exp_q > EW'(4))
         step = 5'd4;
      else if (mant_q[MW-1 -: 2] == '0 && exp_q > EW'(2))
         step = 5'd2;
      else if (mant_q[MW-1] == 1'b0 && exp_q > EW'(1))
         step = 5'd1;
   end

   assign shift_sum = {1'b0, shift_q} + (SW+1)'(step);

   always_comb begin
      state_d = state_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      shift_d = shift_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      uflow_d = uflow_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mant_d  = in_sum;
               exp_d   = in_exp;
               sign_d  = in_sign;
               shift_d = '0;
               zero_d  = 1'b0;
               uflow_d = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (mant_q == '0) begin
               zero_d  = 1'b1;
               exp_d   = '0;
               shift_d = SW'(MW);
               state_d = S_DONE;
            end else if (mant_q[MW-1]) begin
               state_d = S_DONE;
            end else if (step != 5'd0) begin
               mant_d  = mant_q << step;
               exp_d   = exp_q - EW'(step);
               shift_d = (shift_sum > (SW+1)'(MW)) ? SW'(MW) : shift_sum[SW-1:0];
            end else begin
               uflow_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         mant_q  <= '0;
         exp_q   <= '0;
         shift_q <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         uflow_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         shift_q <= shift_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         uflow_q <= uflow_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = valid_q;
   assign out_mant  = mant_q;
   assign out_exp   = exp_q;
   assign out_sign  = sign_q;
   assign out_shift = shift_q;
   assign out_zero  = zero_q;
   assign out_uflow = uflow_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fpaddsub_norm_sequencer.sv
// Bench for fpaddsub_norm_sequencer: directed vector table, reset/backpressure sequences,
// and random operands scored against a closed-form normalization model.
module tb_fpaddsub_norm_sequencer;
   localparam int MW = 26;
   localparam int EW = 8;
   localparam int SW = 5;
   localparam int RW = MW + EW + SW + 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [MW-1:0] in_sum = '0;
   logic [EW-1:0] in_exp = '0;
   logic          in_sign = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [MW-1:0] out_mant;
   logic [EW-1:0] out_exp;
   logic          out_sign;
   logic [SW-1:0] out_shift;
   logic          out_zero;
   logic          out_uflow;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   logic [RW-1:0] exp_q[$];

   fpaddsub_norm_sequencer #(.MW(MW), .EW(EW), .SW(SW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_exp(in_exp), .in_sign(in_sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
      .out_shift(out_shift), .out_zero(out_zero), .out_uflow(out_uflow),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [MW-1:0] sum;
      logic [EW-1:0] e;
      logic          sign;
      logic [MW-1:0] x_mant;
      logic [EW-1:0] x_exp;
      logic [SW-1:0] x_shift;
      logic          x_zero;
      logic          x_uflow;
      int            x_lat;
      int            hold;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [RW-1:0] pack_res(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                             input logic [SW-1:0] s, input logic z,
                                             input logic u, input logic sg);
      return {m, e, s, z, u, sg};
   endfunction

   // Greedy power-of-two shifting always reaches min(leading zeros, exp-1) in total,
   // taking one cycle per set bit of that amount.
   task automatic model(input logic [MW-1:0] sum, input logic [EW-1:0] e, input logic sign,
                        output logic [RW-1:0] r, output int lat);
      int lz, budget, sh;
      if (sum == '0) begin
         r   = pack_res('0, '0, SW'(MW), 1'b1, 1'b0, sign);
         lat = 2;
         return;
      end
      lz = MW;
      for (int i = MW - 1; i >= 0; i--) begin
         if (sum[i]) begin
            lz = MW - 1 - i;
            break;
         end
      end
      budget = (e == 0) ? 0 : int'(e) - 1;
      sh     = (lz < budget) ? lz : budget;
      r      = pack_res(sum << sh, e - EW'(sh), SW'(sh), 1'b0, (sh < lz), sign);
      lat    = 2 + $countones(sh);
   endtask

   task automatic run_op(input logic [MW-1:0] sum, input logic [EW-1:0] e, input logic sign,
                         input int x_lat, input int hold, input string tag);
      int wait_cyc, lat;
      logic [RW-1:0] req, held;
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 10) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_sum   = sum;
      in_exp   = e;
      in_sign  = sign;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sum   = MW'($urandom);
      in_exp   = EW'($urandom);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      chk({tag, "_latency"}, lat, x_lat);
      req = exp_q.pop_front();
      chk({tag, "_result"}, {out_mant, out_exp, out_shift, out_zero, out_uflow, out_sign}, req);
      chk({tag, "_busy"}, in_ready, 1'b0);
      held = {out_mant, out_exp, out_shift, out_zero, out_uflow, out_sign};
      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         in_sum   = MW'($urandom);
         in_exp   = EW'($urandom);
         @(posedge clk); #1;
         chk({tag, "_hold_data"}, {out_mant, out_exp, out_shift, out_zero, out_uflow, out_sign}, held);
         chk({tag, "_hold_valid"}, out_valid, 1'b1);
         chk({tag, "_hold_ready"}, in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 1'b0);
      chk({tag, "_idle_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [RW-1:0] r;
      int            lat;
      logic [MW-1:0] s;
      logic [EW-1:0] e;
      int            pos;

      vecs[0] = '{26'h2000000, 8'd100, 1'b0, 26'h2000000, 8'd100, 5'd0,  1'b0, 1'b0, 2, 0};
      vecs[1] = '{26'h0000001, 8'd100, 1'b0, 26'h2000000, 8'd75,  5'd25, 1'b0, 1'b0, 5, 0};
      vecs[2] = '{26'h0000001, 8'd10,  1'b1, 26'h0000200, 8'd1,   5'd9,  1'b0, 1'b1, 4, 1};
      vecs[3] = '{26'h0000000, 8'd50,  1'b1, 26'h0000000, 8'd0,   5'd26, 1'b1, 1'b0, 2, 0};
      vecs[4] = '{26'h0000004, 8'd200, 1'b0, 26'h2000000, 8'd177, 5'd23, 1'b0, 1'b0, 6, 0};
      vecs[5] = '{26'h1000000, 8'd0,   1'b0, 26'h1000000, 8'd0,   5'd0,  1'b0, 1'b1, 2, 0};
      vecs[6] = '{26'h0800000, 8'd1,   1'b1, 26'h0800000, 8'd1,   5'd0,  1'b0, 1'b1, 2, 0};
      vecs[7] = '{26'h0800000, 8'd3,   1'b0, 26'h2000000, 8'd1,   5'd2,  1'b0, 1'b0, 3, 0};
      vecs[8] = '{26'h3FFFFFF, 8'd0,   1'b1, 26'h3FFFFFF, 8'd0,   5'd0,  1'b0, 1'b0, 2, 0};
      vecs[9] = '{26'h0000100, 8'd18,  1'b0, 26'h2000000, 8'd1,   5'd17, 1'b0, 1'b0, 4, 3};

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_outs", {out_mant, out_exp, out_shift, out_zero, out_uflow, out_sign}, '0);
      chk("reset_in_ready", in_ready, 1'b1);

      foreach (vecs[i]) begin
         exp_q.push_back(pack_res(vecs[i].x_mant, vecs[i].x_exp, vecs[i].x_shift,
                                  vecs[i].x_zero, vecs[i].x_uflow, vecs[i].sign));
         run_op(vecs[i].sum, vecs[i].e, vecs[i].sign, vecs[i].x_lat, vecs[i].hold,
                $sformatf("vec%0d", i));
      end

      // Backpressure in DONE with in_valid pulses that must be ignored.
      exp_q.push_back(pack_res(26'h2000000, 8'd100, 5'd0, 1'b0, 1'b0, 1'b1));
      run_op(26'h2000000, 8'd100, 1'b1, 2, 3, "stall");

      // Reset mid-shift abandons the operand; a following operand completes normally.
      in_valid = 1'b1;
      in_sum   = 26'h0000001;
      in_exp   = 8'd100;
      in_sign  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_outs", {out_mant, out_exp, out_shift, out_zero, out_uflow, out_sign}, '0);
      chk("midrst_in_ready", in_ready, 1'b1);
      exp_q.push_back(pack_res(26'h2000000, 8'd100, 5'd0, 1'b0, 1'b0, 1'b0));
      run_op(26'h2000000, 8'd100, 1'b0, 2, 0, "after_rst");

      for (int n = 0; n < 200; n++) begin
         pos = $urandom_range(0, MW);
         if (pos == MW)
            s = '0;
         else
            s = (MW'(1) << pos) | (MW'($urandom) & ((MW'(1) << pos) - MW'(1)));
         case ($urandom_range(0, 3))
            0:       e = EW'($urandom_range(0, 2));
            1:       e = EW'($urandom_range(3, 30));
            default: e = EW'($urandom_range(0, 255));
         endcase
         model(s, e, 1'($urandom), r, lat);
         exp_q.push_back(r);
         run_op(s, e, r[0], lat, $urandom_range(0, 2), $sformatf("rnd%0d", n));
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
